// File: rtl/servo_pkg.sv
// Shared mode and direction encodings for the servo sweep PWM block.
package servo_pkg;

   localparam logic [1:0] MODE_HOLD   = 2'd0;
   localparam logic [1:0] MODE_WRAP   = 2'd1;
   localparam logic [1:0] MODE_PING   = 2'd2;
   localparam logic [1:0] MODE_DIRECT = 2'd3;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: position/direction sweep state, latched pulse width and registered pwm.
module servo_pwm_channel
   import servo_pkg::*;
#(
   parameter int unsigned POS_W         = 8,
   parameter int unsigned CW            = 21,
   parameter int unsigned PULSE_MIN_CYC = 50_000,
   parameter int unsigned PULSE_LSB_CYC = 784
) (
   input  logic             clk,
   input  logic             reset_p,
   input  logic [CW-1:0]    frame_cnt,
   input  logic             frame_end,
   input  logic             step,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [POS_W-1:0] lo,
   input  logic [POS_W-1:0] hi,
   output logic             pwm,
   output logic [POS_W-1:0] pos
);

   logic [POS_W-1:0] pos_q, pos_d;
   dir_t             dir_q, dir_d;
   logic [CW-1:0]    width_q, width_d;
   logic             en_q, en_d;
   logic             pwm_q, pwm_d;

   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      if (frame_end) begin
         if (mode == MODE_DIRECT) begin
            pos_d = lo;
         end else if (step && (mode == MODE_WRAP || mode == MODE_PING)) begin
            if (pos_q < lo || pos_q > hi) begin
               pos_d = lo;
               dir_d = DIR_UP;
            end else if (lo >= hi) begin
               pos_d = lo;
            end else if (mode == MODE_WRAP) begin
               pos_d = (pos_q >= hi) ? lo : pos_q + POS_W'(1);
            end else if (dir_q == DIR_UP) begin
               // lo < hi and pos in range here, so +/-1 can never wrap
               if (pos_q >= hi) begin
                  dir_d = DIR_DOWN;
                  pos_d = pos_q - POS_W'(1);
               end else begin
                  pos_d = pos_q + POS_W'(1);
               end
            end else begin
               if (pos_q <= lo) begin
                  dir_d = DIR_UP;
                  pos_d = pos_q + POS_W'(1);
               end else begin
                  pos_d = pos_q - POS_W'(1);
               end
            end
         end
      end
   end

   always_comb begin
      width_d = width_q;
      en_d    = en_q;
      if (frame_end) begin
         width_d = CW'(64'(PULSE_MIN_CYC) + 64'(pos_d) * 64'(PULSE_LSB_CYC));
         en_d    = en;
      end
      pwm_d = en_d && (frame_cnt < width_d);
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         pos_q   <= '0;
         dir_q   <= DIR_UP;
         width_q <= '0;
         en_q    <= 1'b0;
         pwm_q   <= 1'b0;
      end else begin
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         width_q <= width_d;
         en_q    <= en_d;
         pwm_q   <= pwm_d;
      end
   end

   assign pwm = pwm_q;
   assign pos = pos_q;

endmodule

// File: rtl/servo_sweep_pwm.sv
// Multi-channel servo PWM: shared frame/step counters, input synchronisers and per-channel sweepers.
module servo_sweep_pwm
   import servo_pkg::*;
#(
   parameter int unsigned NCH           = 2,
   parameter int unsigned POS_W         = 8,
   parameter int unsigned PERIOD_CYC    = 2_000_000,
   parameter int unsigned PULSE_MIN_CYC = 50_000,
   parameter int unsigned PULSE_LSB_CYC = 784,
   parameter int unsigned STEP_FRAMES   = 4
) (
   input  logic                 clk,
   input  logic                 reset_p,
   input  logic [NCH-1:0]       en,
   input  logic [2*NCH-1:0]     mode,
   input  logic [POS_W*NCH-1:0] lo,
   input  logic [POS_W*NCH-1:0] hi,
   output logic [NCH-1:0]       pwm,
   output logic [POS_W*NCH-1:0] pos,
   output logic                 frame_start
);

   localparam int unsigned CW     = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
   localparam int unsigned SW     = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
   localparam int unsigned SYNC_W = NCH * (3 + 2 * POS_W);
   localparam longint unsigned MAX_WIDTH =
      64'(PULSE_MIN_CYC) + ((64'd1 << POS_W) - 64'd1) * 64'(PULSE_LSB_CYC);

   if (MAX_WIDTH >= 64'(PERIOD_CYC)) begin : g_bad_width
      $error("servo_sweep_pwm: longest pulse does not fit in the frame");
   end
   if (STEP_FRAMES < 1) begin : g_bad_step
      $error("servo_sweep_pwm: STEP_FRAMES must be at least 1");
   end

   logic [SYNC_W-1:0]    sync1_q, sync2_q;
   logic [NCH-1:0]       en_s;
   logic [2*NCH-1:0]     mode_s;
   logic [POS_W*NCH-1:0] lo_s, hi_s;

   logic [CW-1:0] frame_cnt_q, frame_cnt_d;
   logic [SW-1:0] step_cnt_q, step_cnt_d;
   logic          frame_start_q;
   logic          frame_end, step;

   assign {en_s, mode_s, lo_s, hi_s} = sync2_q;

   always_comb begin
      frame_end   = (frame_cnt_q == CW'(PERIOD_CYC - 1));
      step        = (step_cnt_q == SW'(STEP_FRAMES - 1));
      frame_cnt_d = frame_end ? '0 : frame_cnt_q + CW'(1);
      step_cnt_d  = step_cnt_q;
      if (frame_end) begin
         step_cnt_d = step ? '0 : step_cnt_q + SW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         frame_cnt_q   <= '0;
         step_cnt_q    <= '0;
         frame_start_q <= 1'b0;
      end else begin
         sync1_q       <= {en, mode, lo, hi};
         sync2_q       <= sync1_q;
         frame_cnt_q   <= frame_cnt_d;
         step_cnt_q    <= step_cnt_d;
         frame_start_q <= frame_end;
      end
   end

   assign frame_start = frame_start_q;

   // Channels get the next count so their registered pwm lines up with frame_cnt.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      servo_pwm_channel #(
         .POS_W         (POS_W),
         .CW            (CW),
         .PULSE_MIN_CYC (PULSE_MIN_CYC),
         .PULSE_LSB_CYC (PULSE_LSB_CYC)
      ) u_ch (
         .clk       (clk),
         .reset_p   (reset_p),
         .frame_cnt (frame_cnt_d),
         .frame_end (frame_end),
         .step      (step),
         .en        (en_s[i]),
         .mode      (mode_s[2*i +: 2]),
         .lo        (lo_s[POS_W*i +: POS_W]),
         .hi        (hi_s[POS_W*i +: POS_W]),
         .pwm       (pwm[i]),
         .pos       (pos[POS_W*i +: POS_W])
      );
   end

endmodule

// File: tb/tb_servo_sweep_pwm.sv
// Bench for servo_sweep_pwm: directed scenarios plus random switch settings against a frame model.
module tb_servo_sweep_pwm;

   localparam int unsigned NCH   = 2;
   localparam int unsigned POS_W = 4;
   localparam int unsigned P     = 100;
   localparam int unsigned MIN   = 10;
   localparam int unsigned LSB   = 2;
   localparam int unsigned S     = 1;

   logic                 clk;
   logic                 reset_p;
   logic [NCH-1:0]       en;
   logic [2*NCH-1:0]     mode;
   logic [POS_W*NCH-1:0] lo;
   logic [POS_W*NCH-1:0] hi;
   logic [NCH-1:0]       pwm;
   logic [POS_W*NCH-1:0] pos;
   logic                 frame_start;

   servo_sweep_pwm #(
      .NCH           (NCH),
      .POS_W         (POS_W),
      .PERIOD_CYC    (P),
      .PULSE_MIN_CYC (MIN),
      .PULSE_LSB_CYC (LSB),
      .STEP_FRAMES   (S)
   ) dut (
      .clk         (clk),
      .reset_p     (reset_p),
      .en          (en),
      .mode        (mode),
      .lo          (lo),
      .hi          (hi),
      .pwm         (pwm),
      .pos         (pos),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int k, nfr;
   int m_pos[NCH], m_dir[NCH], m_width[NCH], m_en[NCH];
   int hc[NCH], last_hi[NCH];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, k, got, exp);
      end
   endtask

   task automatic set_ch(input int ch, input int e, input int m, input int l, input int h);
      en[ch]                 = e[0];
      mode[2*ch +: 2]        = 2'(m);
      lo[POS_W*ch +: POS_W]  = POS_W'(l);
      hi[POS_W*ch +: POS_W]  = POS_W'(h);
   endtask

   task automatic model_reset();
      k = 0;
      nfr = 0;
      for (int c = 0; c < NCH; c++) begin
         m_pos[c] = 0; m_dir[c] = 0; m_width[c] = 0; m_en[c] = 0;
         hc[c] = 0; last_hi[c] = 0;
      end
   endtask

   // Frame-end rules applied with plain integers; dir 0 = up, 1 = down.
   task automatic model_frame_end();
      nfr++;
      for (int c = 0; c < NCH; c++) begin
         int m, l, h, p;
         m = int'(mode[2*c +: 2]);
         l = int'(lo[POS_W*c +: POS_W]);
         h = int'(hi[POS_W*c +: POS_W]);
         p = m_pos[c];
         if (m == 3) begin
            p = l;
         end else if ((m == 1 || m == 2) && (nfr % S) == 0) begin
            if (p < l || p > h) begin
               p = l; m_dir[c] = 0;
            end else if (l >= h) begin
               p = l;
            end else if (m == 1) begin
               p = (p == h) ? l : p + 1;
            end else if (m_dir[c] == 0) begin
               if (p == h) begin m_dir[c] = 1; p = p - 1; end
               else p = p + 1;
            end else begin
               if (p == l) begin m_dir[c] = 0; p = p + 1; end
               else p = p - 1;
            end
         end
         m_pos[c]   = p;
         m_width[c] = MIN + p * LSB;
         m_en[c]    = int'(en[c]);
      end
   endtask

   task automatic sample();
      logic [NCH-1:0]       e_pwm;
      logic [POS_W*NCH-1:0] e_pos;
      int cnt;
      cnt = k % P;
      for (int c = 0; c < NCH; c++) begin
         e_pwm[c] = (m_en[c] != 0) && (cnt < m_width[c]);
         e_pos[POS_W*c +: POS_W] = POS_W'(m_pos[c]);
      end
      check_eq("pwm", 32'(pwm), 32'(e_pwm));
      check_eq("frame_start", 32'(frame_start), 32'((k > 0) && (cnt == 0)));
      check_eq("pos", 32'(pos), 32'(e_pos));
      for (int c = 0; c < NCH; c++) hc[c] += int'(pwm[c]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
      if (k % P == 0) begin
         model_frame_end();
         for (int c = 0; c < NCH; c++) begin last_hi[c] = hc[c]; hc[c] = 0; end
      end
      sample();
   endtask

   task automatic run_to(input int t);
      do tick(); while (k % P != t);
   endtask

   task automatic run_to_start();
      run_to(0);
   endtask

   int wrap_pos[5] = '{4, 5, 6, 3, 4};
   int wrap_wid[5] = '{16, 18, 20, 22, 16};
   int ping_pos[6] = '{5, 6, 5, 4, 3, 4};

   initial begin
      reset_p = 1'b1;
      en = '0; mode = '0; lo = '0; hi = '0;
      model_reset();
      set_ch(0, 1, 3, 5, 0);
      set_ch(1, 0, 1, 2, 9);
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_pwm", 32'(pwm), 32'd0);
      check_eq("rst_pos", 32'(pos), 32'd0);
      check_eq("rst_fs", 32'(frame_start), 32'd0);
      @(posedge clk);
      #1 reset_p = 1'b0;
      sample();

      // DIRECT at lo=5: first frame low, then 20-cycle pulses; ch1 disabled
      run_to_start();
      check_eq("t1_first_low", 32'(last_hi[0]), 32'd0);
      repeat (2) begin
         run_to_start();
         check_eq("t1_width", 32'(last_hi[0]), 32'd20);
         check_eq("t1_ch1_off", 32'(last_hi[1]), 32'd0);
      end

      run_to(50); set_ch(0, 1, 3, 3, 0);
      run_to_start();
      check_eq("t2_start", 32'(pos[3:0]), 32'd3);
      run_to(50); set_ch(0, 1, 1, 3, 6);
      for (int i = 0; i < 5; i++) begin
         run_to_start();
         check_eq("t2_wrap_pos", 32'(pos[3:0]), 32'(wrap_pos[i]));
         check_eq("t2_wrap_width", 32'(last_hi[0]), 32'(wrap_wid[i]));
      end

      run_to(50); set_ch(0, 1, 2, 3, 6);
      for (int i = 0; i < 6; i++) begin
         run_to_start();
         check_eq("t3_ping_pos", 32'(pos[3:0]), 32'(ping_pos[i]));
      end
      run_to(50); set_ch(0, 1, 2, 7, 7);
      repeat (3) begin
         run_to_start();
         check_eq("t3_pinned", 32'(pos[3:0]), 32'd7);
      end

      run_to(50); set_ch(0, 1, 1, 0, 15);
      for (int i = 0; i < 10; i++) begin
         int prev;
         prev = (i == 0) ? 7 : (7 + i) % 16;
         run_to_start();
         check_eq("t4_pos", 32'(pos[3:0]), 32'((8 + i) % 16));
         check_eq("t4_width", 32'(last_hi[0]), 32'(MIN + prev * LSB));
      end

      run_to(50); set_ch(0, 1, 3, 3, 0);
      run_to_start();
      run_to(50); set_ch(0, 1, 1, 3, 12);
      run_to_start();
      check_eq("t5_pos4", 32'(pos[3:0]), 32'd4);
      run_to(5); set_ch(0, 1, 1, 9, 12);
      run_to_start();
      check_eq("t5_pulse_kept", 32'(last_hi[0]), 32'd18);
      check_eq("t5_pos_lo", 32'(pos[3:0]), 32'd9);
      run_to(5);
      check_eq("t5_mid_pulse", 32'(pwm[0]), 32'd1);
      set_ch(0, 0, 1, 9, 12);
      run_to_start();
      check_eq("t5_full_pulse", 32'(last_hi[0]), 32'd28);
      run_to_start();
      check_eq("t5_disabled", 32'(last_hi[0]), 32'd0);
      check_eq("t5_pos_moves", 32'(pos[3:0]), 32'd11);

      run_to(50); set_ch(0, 1, 1, 9, 12);
      run_to_start();
      run_to(7);
      check_eq("t6_pre_rst", 32'(pwm[0]), 32'd1);
      reset_p = 1'b1;
      #1;
      check_eq("t6_rst_pwm", 32'(pwm), 32'd0);
      check_eq("t6_rst_pos", 32'(pos), 32'd0);
      check_eq("t6_rst_fs", 32'(frame_start), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_p = 1'b0;
      model_reset();
      sample();
      run_to_start();
      check_eq("t6_first_low", 32'(last_hi[0]), 32'd0);
      check_eq("t6_pos", 32'(pos[3:0]), 32'd9);
      run_to_start();
      check_eq("t6_width", 32'(last_hi[0]), 32'd28);

      // Random switch settings, changed mid-frame well clear of frame end
      for (int f = 0; f < 40; f++) begin
         run_to(int'($urandom_range(P - 6, 1)));
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(1, 0) == 1) begin
               int e, m, l, h;
               e = int'($urandom_range(1, 0));
               m = int'($urandom_range(3, 0));
               l = int'($urandom_range(15, 0));
               h = int'($urandom_range(15, 0));
               if (m == 2 && l >= h) begin
                  if (l == 15) l = 14;
                  h = l + 1;
               end
               set_ch(c, e, m, l, h);
            end
         end
         run_to_start();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
